// File: rtl/mem_access_unit.sv
// Load/store front end for the 256-byte data memory: sequences LOAD/STORE/PUSH/POP,
// owns the stack pointer and suppresses repeat writes from the same program counter.
module mem_access_unit #(
  parameter int unsigned    AW       = 8,
  parameter int unsigned    DW       = 8,
  parameter int unsigned    PCW      = 12,
  parameter logic [AW-1:0]  SP_RESET = 8'hFF,
  parameter logic [AW-1:0]  SP_LIMIT = 8'hC0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_op,
  input  logic [AW-1:0]  req_addr,
  input  logic [DW-1:0]  req_wdata,
  input  logic [PCW-1:0] prog_ctr,
  output logic           rsp_valid,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_err,
  output logic [AW-1:0]  sp_out,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_dat_in,
  output logic           mem_wr_en,
  input  logic [DW-1:0]  mem_dat_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_STORE = 2'b01,
                            OP_PUSH = 2'b10, OP_POP = 2'b11} op_e;

  // Stack is full when the pointer sits one below the floor.
  localparam logic [AW-1:0] SP_FULL = SP_LIMIT - AW'(1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic           dup_q, dup_d;
  logic [PCW-1:0] last_pc_q, last_pc_d;

  logic           req_ready_d, rsp_valid_d, rsp_err_d, mem_wr_en_d;
  logic [DW-1:0]  rsp_data_d, mem_dat_in_d;
  logic [AW-1:0]  sp_d, mem_addr_d;
  logic           req_dup_c, ovf_c, unf_c;

  // State and every output are registered; memory controls are set up on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_LOAD;
      dup_q      <= 1'b0;
      last_pc_q  <= '1;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      sp_out     <= SP_RESET;
      mem_addr   <= '0;
      mem_dat_in <= '0;
      mem_wr_en  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dup_q      <= dup_d;
      last_pc_q  <= last_pc_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_err    <= rsp_err_d;
      sp_out     <= sp_d;
      mem_addr   <= mem_addr_d;
      mem_dat_in <= mem_dat_in_d;
      mem_wr_en  <= mem_wr_en_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dup_d        = dup_q;
    last_pc_d    = last_pc_q;
    req_ready_d  = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    sp_d         = sp_out;
    mem_addr_d   = '0;
    mem_dat_in_d = '0;
    mem_wr_en_d  = 1'b0;
    req_dup_c    = (prog_ctr == last_pc_q);
    ovf_c        = (sp_out == SP_FULL);
    unf_c        = (sp_out == SP_RESET);

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          state_d     = ACCESS;
          req_ready_d = 1'b0;
          op_d        = op_e'(req_op);
          dup_d       = req_dup_c;
          if (!req_dup_c) last_pc_d = prog_ctr;
          unique case (op_e'(req_op))
            OP_LOAD:  mem_addr_d = req_addr;
            OP_STORE: begin
              mem_addr_d   = req_addr;
              mem_dat_in_d = req_wdata;
              mem_wr_en_d  = !req_dup_c;
            end
            OP_PUSH: begin
              mem_addr_d   = sp_out;
              mem_dat_in_d = req_wdata;
              mem_wr_en_d  = !req_dup_c && !ovf_c;
            end
            OP_POP:   mem_addr_d = sp_out + AW'(1);
          endcase
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        // A repeated PC leaves the stack pointer and previous response data untouched.
        if (!dup_q) begin
          rsp_data_d = '0;
          unique case (op_q)
            OP_LOAD:  rsp_data_d = mem_dat_out;
            OP_STORE: rsp_data_d = '0;
            OP_PUSH: begin
              if (ovf_c) rsp_err_d = 1'b1;
              else       sp_d      = sp_out - AW'(1);
            end
            OP_POP: begin
              if (unf_c) begin
                rsp_err_d = 1'b1;
              end else begin
                rsp_data_d = mem_dat_out;
                sp_d       = sp_out + AW'(1);
              end
            end
          endcase
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: emulates the data memory and checks directed and random
// requests against a depth-based stack/memory reference model.
module tb_mem_access_unit;

  localparam logic [1:0] LOAD = 2'b00, STORE = 2'b01, PUSH = 2'b10, POP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [11:0] prog_ctr = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  sp_out;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_dat_in;
  logic        mem_wr_en;
  logic [7:0]  mem_dat_out;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .prog_ctr(prog_ctr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .sp_out(sp_out),
    .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_wr_en(mem_wr_en),
    .mem_dat_out(mem_dat_out)
  );

  always #5 clk = ~clk;

  // Data memory emulation with a write monitor.
  logic [7:0] dmem [256];
  int         wr_cnt = 0;
  logic [7:0] last_wr_addr = '0, last_wr_data = '0;
  assign mem_dat_out = dmem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) begin
      dmem[mem_addr] <= mem_dat_in;
      wr_cnt         <= wr_cnt + 1;
      last_wr_addr   <= mem_addr;
      last_wr_data   <= mem_dat_in;
    end
  end

  // Reference model: stack described by its depth below the top of memory.
  logic [7:0]  model_mem [256];
  int          m_depth = 0;
  logic [11:0] m_last_pc = 12'hFFF;
  logic [7:0]  m_rsp_data = '0;

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [11:0] pc);
    logic       dup, exp_err, exp_wr;
    logic [7:0] exp_eff, exp_wa, sp_now;
    int         wr0, waited;
    dup     = (pc == m_last_pc);
    if (!dup) m_last_pc = pc;
    sp_now  = 8'(255 - m_depth);
    exp_err = 1'b0;
    exp_wr  = 1'b0;
    exp_wa  = '0;
    exp_eff = (op == PUSH) ? sp_now : (op == POP) ? 8'(sp_now + 8'd1) : addr;
    if (!dup) begin
      m_rsp_data = '0;
      case (op)
        LOAD:  m_rsp_data = model_mem[addr];
        STORE: begin model_mem[addr] = wdata; exp_wr = 1'b1; exp_wa = addr; end
        PUSH: begin
          if (m_depth == 64) exp_err = 1'b1;
          else begin
            exp_wr = 1'b1; exp_wa = sp_now;
            model_mem[sp_now] = wdata;
            m_depth++;
          end
        end
        default: begin
          if (m_depth == 0) exp_err = 1'b1;
          else begin
            m_depth--;
            m_rsp_data = model_mem[8'(255 - m_depth)];
          end
        end
      endcase
    end

    waited = 0;
    while (req_ready !== 1'b1 && waited < 10) begin @(posedge clk); #1; waited++; end
    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; prog_ctr = pc;
    wr0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("ready_in_access", 32'(req_ready), 32'd0);
    check("mem_addr_access", 32'(mem_addr), 32'(exp_eff));
    check("wr_en_access", 32'(mem_wr_en), 32'(exp_wr));
    @(posedge clk); #1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("sp_out", 32'(sp_out), 32'(255 - m_depth));
    check("write_count", 32'(wr_cnt - wr0), 32'(exp_wr));
    check("wr_en_resp", 32'(mem_wr_en), 32'd0);
    if (exp_wr) begin
      check("write_addr", 32'(last_wr_addr), 32'(exp_wa));
      check("write_data", 32'(last_wr_data), 32'(wdata));
    end
    @(posedge clk); #1;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("rsp_data_hold", 32'(rsp_data), 32'(m_rsp_data));
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wr0;
    logic [11:0] pc;
    for (int i = 0; i < 256; i++) begin
      dmem[i]      = 8'($urandom);
      model_mem[i] = dmem[i];
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sp", 32'(sp_out), 32'hFF);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset during the ACCESS cycle of a STORE abandons it
    req_valid = 1'b1; req_op = STORE; req_addr = 8'h30; req_wdata = 8'hEE; prog_ctr = 12'h100;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_wr_en_set", 32'(mem_wr_en), 32'd1);
    wr0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(mem_wr_en), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_sp", 32'(sp_out), 32'hFF);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("mid_rst_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_idle", 32'(req_ready), 32'd1);
    check("mid_rst_mem", 32'(dmem[8'h30]), 32'(model_mem[8'h30]));

    // Store then load
    do_req(STORE, 8'h10, 8'h5A, 12'd1);
    do_req(LOAD, 8'h10, 8'h00, 12'd2);
    check("load_5a", 32'(rsp_data), 32'h5A);

    // Push three, pop three
    do_req(PUSH, 8'h00, 8'h11, 12'd3);
    do_req(PUSH, 8'h00, 8'h22, 12'd4);
    do_req(PUSH, 8'h00, 8'h33, 12'd5);
    check("sp_after_push3", 32'(sp_out), 32'hFC);
    do_req(POP, 8'h00, 8'h00, 12'd6);
    check("pop_33", 32'(rsp_data), 32'h33);
    do_req(POP, 8'h00, 8'h00, 12'd7);
    check("pop_22", 32'(rsp_data), 32'h22);
    do_req(POP, 8'h00, 8'h00, 12'd8);
    check("pop_11", 32'(rsp_data), 32'h11);

    // Underflow
    do_req(POP, 8'h00, 8'h00, 12'h020);
    check("underflow_err", 32'(rsp_err), 32'd1);

    // Fill the stack, then overflow
    for (int i = 0; i < 64; i++) do_req(PUSH, 8'h00, 8'(i + 1), 12'(12'h021 + i));
    check("sp_full", 32'(sp_out), 32'hBF);
    do_req(PUSH, 8'h00, 8'hAB, 12'h061);
    check("overflow_err", 32'(rsp_err), 32'd1);
    for (int i = 0; i < 64; i++) do_req(POP, 8'h00, 8'h00, 12'(12'h062 + i));
    check("sp_drained", 32'(sp_out), 32'hFF);

    // Same-PC repeated store is suppressed
    do_req(STORE, 8'h20, 8'h77, 12'd9);
    do_req(STORE, 8'h20, 8'h88, 12'd9);
    check("dup_mem_holds", 32'(dmem[8'h20]), 32'h77);
    do_req(STORE, 8'h20, 8'h88, 12'd10);
    check("new_pc_writes", 32'(dmem[8'h20]), 32'h88);

    // Randomized traffic with occasional repeated PCs
    pc = 12'd11;
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [1:0] op;
      r  = int'($urandom_range(0, 9));
      op = (r < 2) ? LOAD : (r < 4) ? STORE : (r < 7) ? PUSH : POP;
      if ($urandom_range(0, 4) != 0) pc = 12'($urandom_range(0, 12'hFFE));
      do_req(op, 8'($urandom), 8'($urandom), pc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of the 256-byte data memory; it is the only block that drives the memory's addr, dat_in and wr_en.
- Accepts one LOAD, STORE, PUSH or POP request at a time from the core over a valid/ready handshake, sequences the memory access and returns a registered response.
- Owns the hardware stack pointer and checks for stack overflow and underflow.
- Guarantees at most one memory write per program-counter value.

Parameters:
AW, 8, address width (memory depth 2^AW bytes)
DW, 8, data width
PCW, 12, program counter width
SP_RESET, 8'hFF, stack pointer reset value (empty stack, top of memory)
SP_LIMIT, 8'hC0, lowest legal stack address (stack floor)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  2  00 LOAD, 01 STORE, 10 PUSH, 11 POP
req_addr  in  AW  address for LOAD/STORE (ignored for PUSH/POP)
req_wdata  in  DW  data for STORE/PUSH
prog_ctr  in  PCW  PC of the requesting instruction
rsp_valid  out  1  one-cycle response strobe
rsp_data  out  DW  load/pop data; 0 for stores and errors
rsp_err  out  1  stack overflow/underflow on this response
sp_out  out  AW  current stack pointer
mem_addr  out  AW  to data memory addr
mem_dat_in  out  DW  to data memory dat_in
mem_wr_en  out  1  to data memory wr_en
mem_dat_out  in  DW  from data memory (combinational read)

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0; sp_out=SP_RESET; mem_addr=0; mem_dat_in=0; mem_wr_en=0; last_pc=all ones.
- A reset asserted mid-operation drops mem_wr_en immediately and abandons the request. No response is issued for it.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid=1, latch op, addr, wdata and the dup flag (prog_ctr==last_pc), then go to ACCESS. If not dup, last_pc<=prog_ctr (this applies to erroring requests too).
- ACCESS (exactly 1 cycle): req_ready=0; mem_addr is driven from the effective address; go to RESP.
  - LOAD: eff=addr; rsp_data<=mem_dat_out at end of cycle.
  - STORE: eff=addr; mem_wr_en=1, mem_dat_in=wdata.
  - PUSH: eff=sp. If sp==SP_LIMIT-1, overflow: err, no write, sp unchanged. Otherwise write, then sp<=sp-1 (post-decrement).
  - POP: eff=sp+1. If sp==SP_RESET, underflow: err, rsp_data<=0, sp unchanged. Otherwise rsp_data<=mem_dat_out, then sp<=sp+1 (pre-increment).
  - Dup request: mem_wr_en held 0, sp unchanged, rsp_data keeps its previous value, no error.
- RESP (exactly 1 cycle): rsp_valid=1 with rsp_data/rsp_err valid; go to IDLE. rsp_data/rsp_err hold until the next ACCESS.
- Latency: accept at edge N, write (if any) on edge N+1, rsp_valid high during cycle N+2. Throughput is 1 request per 3 cycles.
- mem_wr_en is high only in ACCESS, for at most one cycle per request.
- Outside ACCESS: mem_addr=0, mem_dat_in=0.
- Stack capacity is SP_RESET-SP_LIMIT+1 entries (64 by default). SP arithmetic is modulo 2^AW, but the checks prevent leaving [SP_LIMIT-1, SP_RESET].
- STORE/LOAD to stack addresses is not checked.
- Requests with req_valid=1 while req_ready=0 are not accepted. The core must hold them until ready.

Test Plan:
- Reset -> sp_out=FF, req_ready=1, rsp_valid=0, mem_wr_en=0; assert rst_n low mid-ACCESS of a STORE -> no write observed, sp_out=FF, state IDLE.
- STORE addr 10 data 5A (pc 1), then LOAD addr 10 (pc 2) -> exactly one mem_wr_en pulse at addr 10; LOAD rsp_data=5A two cycles after accept, rsp_err=0.
- PUSH 11,22,33 (pc 3-5) -> writes at FF,FE,FD, sp_out=FC; POP x3 -> rsp_data 33,22,11, sp_out=FF.
- POP on empty stack -> rsp_err=1, rsp_data=0, no write, sp_out=FF.
- Push 64 bytes -> sp_out=BF, all rsp_err=0; 65th PUSH -> rsp_err=1, no mem_wr_en, sp_out=BF.
- STORE addr 20 data 77 pc 9, repeated STORE addr 20 data 88 pc 9 -> second request gets a response but no write (memory holds 77); a third STORE with pc 10 writes 88.
